// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage and IF/ID pipeline register.
//
// Holds the PC and keeps at most one request to instruction memory outstanding.
// Fetched words go into the IF/ID register, or into a one-entry buffer while decode
// is stalled. A taken branch from decode redirects the PC and flushes wrong-path
// work. Fetch stops on the HLT opcode until a redirect arrives.
//
// Ports:
//   clk, rst          core clock; synchronous active-high reset
//   stall             hold IF/ID contents (hazard unit)
//   branch, target_pc redirect request from decode and its target address
//   imem_req/addr     one-cycle request strobe and byte address (= pc)
//   imem_valid/rdata  memory response, arrives one or more cycles after the request
//   ifid_valid/instr/pc_plus_two  IF/ID register outputs
//   halted            fetch is stopped on HLT
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic [15:0] target_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  output logic        ifid_valid,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus_two,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] pc;
  logic [15:0] pc_plus_two;
  logic        buf_valid;
  logic [15:0] buf_instr;
  logic [15:0] buf_pc_plus_two;
  logic        squash;

  logic        resp_live;
  logic        resp_halt;

  // A response is only usable in WAIT when no redirect has invalidated it.
  assign pc_plus_two = pc + 16'd2;
  assign resp_live   = (state == S_WAIT) && imem_valid && !squash;
  assign resp_halt   = resp_live && (imem_rdata[15:12] == HALT_OPCODE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (branch) begin
      // A request still in flight keeps us in WAIT so its late response can be
      // absorbed (squash); otherwise restart fetching at the target.
      if ((state == S_WAIT) && !imem_valid) begin
        state_next = S_WAIT;
      end else begin
        state_next = S_FETCH;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (!buf_valid) begin
            state_next = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_valid) begin
            if (resp_halt) begin
              state_next = S_HALTED;
            end else begin
              state_next = S_FETCH;
            end
          end
        end
        S_HALTED: begin
          state_next = S_HALTED;
        end
        default: begin
          state_next = S_FETCH;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    imem_req  = !rst && (state == S_FETCH) && !buf_valid && !branch;
    imem_addr = pc;
    halted    = (state == S_HALTED);
  end

  // PC, buffer and IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc               <= RESET_PC;
      ifid_valid       <= 1'b0;
      ifid_instr       <= '0;
      ifid_pc_plus_two <= '0;
      buf_valid        <= 1'b0;
      buf_instr        <= '0;
      buf_pc_plus_two  <= '0;
      squash           <= 1'b0;
    end else if (branch) begin
      pc         <= target_pc;
      ifid_valid <= 1'b0;
      buf_valid  <= 1'b0;
      squash     <= (state == S_WAIT) && !imem_valid;
    end else begin
      if ((state == S_WAIT) && imem_valid) begin
        squash <= 1'b0;
      end
      if (resp_live) begin
        pc <= pc_plus_two;
      end
      if (!stall) begin
        if (buf_valid) begin
          // Buffered word has priority; a simultaneous response refills the buffer.
          ifid_valid       <= 1'b1;
          ifid_instr       <= buf_instr;
          ifid_pc_plus_two <= buf_pc_plus_two;
          buf_valid        <= resp_live;
          if (resp_live) begin
            buf_instr       <= imem_rdata;
            buf_pc_plus_two <= pc_plus_two;
          end
        end else if (resp_live) begin
          ifid_valid       <= 1'b1;
          ifid_instr       <= imem_rdata;
          ifid_pc_plus_two <= pc_plus_two;
        end else begin
          ifid_valid <= 1'b0;
        end
      end else if (resp_live) begin
        buf_valid       <= 1'b1;
        buf_instr       <= imem_rdata;
        buf_pc_plus_two <= pc_plus_two;
      end
    end
  end

endmodule
